// File: rtl/if_id_pipe_buffer_pkg.sv
// Shared types and constants for the IF/ID pipeline buffer.
package if_id_pipe_buffer_pkg;

  localparam int unsigned DEF_INSTR_W = 16;
  localparam int unsigned DEF_IMM_W   = 16;
  localparam int unsigned DEF_PC_W    = 32;

  // Instruction word used for bubbles; all-zero decodes as NOP.
  localparam int unsigned NOP_INSTR = 0;

  // Fetch/decode payload at the default field widths.
  typedef struct packed {
    logic [DEF_INSTR_W-1:0] instruction;
    logic [DEF_IMM_W-1:0]   imm;
    logic [DEF_PC_W-1:0]    pc;
    logic [DEF_PC_W-1:0]    nextPC;
  } if_id_payload_t;

endpackage

// File: rtl/if_id_pipe_buffer_slot.sv
// Single payload+valid register with clear (priority) and load.
module pipe_skid_slot #(
  parameter int unsigned    W         = 1,
  parameter logic [W-1:0]   CLEAR_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  // Next state: clear wins over load, otherwise hold.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clear) begin
      valid_d = 1'b0;
      data_d  = CLEAR_VAL;
    end else if (load) begin
      valid_d = 1'b1;
      data_d  = d;
    end
  end

  // State register; reset leaves the slot empty with a bubble payload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= CLEAR_VAL;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign q     = data_q;

endmodule

// File: rtl/if_id_pipe_buffer.sv
// IF/ID pipeline register with valid/ready flow control, flush, optional
// skid entry and a saturating back-pressure counter.
module if_id_pipe_buffer
  import if_id_pipe_buffer_pkg::*;
#(
  parameter int unsigned INSTR_W = DEF_INSTR_W,
  parameter int unsigned IMM_W   = DEF_IMM_W,
  parameter int unsigned PC_W    = DEF_PC_W,
  parameter int unsigned SKID_EN = 1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] instruction,
  input  logic [IMM_W-1:0]   imm,
  input  logic [PC_W-1:0]    pc,
  input  logic [PC_W-1:0]    nextPC,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] oInstruction,
  output logic [IMM_W-1:0]   oimm,
  output logic [PC_W-1:0]    oPc,
  output logic [PC_W-1:0]    oNextPC,
  output logic [CNT_W-1:0]   stall_cycles
);

  typedef struct packed {
    logic [INSTR_W-1:0] instruction;
    logic [IMM_W-1:0]   imm;
    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    nextPC;
  } payload_t;

  localparam int unsigned PayloadW = $bits(payload_t);
  localparam payload_t    Bubble   = '{instruction: INSTR_W'(NOP_INSTR), imm: '0,
                                       pc: '0, nextPC: '0};

  payload_t in_pl, head_pl, head_d, skid_pl;
  logic     head_valid, skid_valid;
  logic     accept, consume, head_free;
  logic     head_take_skid, head_take_in, head_load, head_clear;
  logic [CNT_W-1:0] stall_q, stall_d;

  assign in_pl = '{instruction: instruction, imm: imm, pc: pc, nextPC: nextPC};

  // Handshakes and head refill decisions; skid contents always go first.
  always_comb begin
    accept         = in_valid & in_ready;
    consume        = head_valid & out_ready;
    head_free      = consume | ~head_valid;
    head_take_skid = skid_valid & head_free;
    head_take_in   = ~skid_valid & accept & head_free;
    head_load      = ~flush & (head_take_skid | head_take_in);
    head_clear     = flush | (consume & ~head_load);
    head_d         = skid_valid ? skid_pl : in_pl;
  end

  pipe_skid_slot #(
    .W         (PayloadW),
    .CLEAR_VAL (Bubble)
  ) u_head (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (head_load),
    .clear (head_clear),
    .d     (head_d),
    .valid (head_valid),
    .q     (head_pl)
  );

  if (SKID_EN != 0) begin : g_skid
    logic skid_load, skid_clear;

    // Input parks in the skid whenever the head cannot take it directly.
    assign skid_load  = ~flush & accept & ~head_take_in;
    assign skid_clear = flush | (head_take_skid & ~skid_load);

    pipe_skid_slot #(
      .W         (PayloadW),
      .CLEAR_VAL (Bubble)
    ) u_skid (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (skid_load),
      .clear (skid_clear),
      .d     (in_pl),
      .valid (skid_valid),
      .q     (skid_pl)
    );

    // Straight from a flop: no path from out_ready.
    assign in_ready = ~skid_valid;
  end else begin : g_no_skid
    assign skid_valid = 1'b0;
    assign skid_pl    = Bubble;
    assign in_ready   = ~head_valid | out_ready;
  end

  // Back-pressure counter next state, saturating at all-ones.
  always_comb begin
    stall_d = stall_q;
    if (head_valid && !out_ready && !flush && !(&stall_q)) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  // Counter register, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign out_valid    = head_valid;
  assign oInstruction = head_pl.instruction;
  assign oimm         = head_pl.imm;
  assign oPc          = head_pl.pc;
  assign oNextPC      = head_pl.nextPC;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_if_id_pipe_buffer.sv
// Bench for if_id_pipe_buffer: a skid instance checked by a vector table and
// an occupancy/payload scoreboard, and a no-skid instance with a 2-bit counter.
module tb_if_id_pipe_buffer;
  import if_id_pipe_buffer_pkg::*;

  logic        clk, rst_n;
  logic        flush, in_valid, out_ready;
  logic        flush0, in_valid0, out_ready0;
  logic [15:0] instruction, imm;
  logic [31:0] pc, next_pc;

  logic        in_ready, out_valid;
  logic [15:0] o_instr, o_imm, stall;
  logic [31:0] o_pc, o_npc;

  logic        in_ready0, out_valid0;
  logic [15:0] o_instr0, o_imm0;
  logic [31:0] o_pc0, o_npc0;
  logic [1:0]  stall0;

  int checks = 0;
  int errors = 0;
  int n_consumed = 0;

  if_id_payload_t sb_q[$];
  logic [15:0]    stall_exp;

  if_id_pipe_buffer dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .imm(imm), .pc(pc), .nextPC(next_pc),
    .out_valid(out_valid), .out_ready(out_ready), .oInstruction(o_instr), .oimm(o_imm),
    .oPc(o_pc), .oNextPC(o_npc), .stall_cycles(stall)
  );

  if_id_pipe_buffer #(.SKID_EN(0), .CNT_W(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush0), .in_valid(in_valid0), .in_ready(in_ready0),
    .instruction(instruction), .imm(imm), .pc(pc), .nextPC(next_pc),
    .out_valid(out_valid0), .out_ready(out_ready0), .oInstruction(o_instr0), .oimm(o_imm0),
    .oPc(o_pc0), .oNextPC(o_npc0), .stall_cycles(stall0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_payload(input logic [31:0] p);
    pc      = p;
    next_pc = p + 32'd1;
    if (p == 32'h10) begin
      instruction = 16'h1234;
      imm         = 16'h00AA;
    end else begin
      instruction = p[15:0] ^ 16'hA5A5;
      imm         = ~p[15:0];
    end
  endtask

  // Drive one cycle on the skid instance; returns at posedge+1.
  task automatic cyc(input logic iv, input logic ordy, input logic fl, input logic [31:0] p);
    in_valid  = iv;
    out_ready = ordy;
    flush     = fl;
    set_payload(p);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: occupancy model predicts valid/ready; payload popped on consume.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
      stall_exp = '0;
    end else begin
      int occ;
      if_id_payload_t exp_pl;
      occ = sb_q.size();
      chk("mon_out_valid", out_valid, occ > 0);
      chk("mon_in_ready", in_ready, occ < 2);
      chk("mon_stall", stall, stall_exp);
      if (!out_valid) chk("mon_bubble_zero", {o_instr, o_imm, o_pc, o_npc}, '0);
      if (out_valid && out_ready) begin
        if (occ == 0) begin
          checks++;
          errors++;
          $display("FAIL mon_unexpected_output: got pc %0h expected none", o_pc);
        end else begin
          exp_pl = sb_q.pop_front();
          chk("mon_payload", {o_instr, o_imm, o_pc, o_npc}, exp_pl);
          n_consumed++;
        end
      end
      if (occ > 0 && !out_ready && !flush && stall_exp != 16'hFFFF) stall_exp++;
      if (flush) sb_q.delete();
      else if (in_valid && occ < 2) sb_q.push_back({instruction, imm, pc, next_pc});
    end
  end

  typedef struct {
    logic        iv, ordy, fl;
    logic [31:0] pcv;
    logic        ov, ir;
    logic [31:0] opc;
    logic [15:0] st;
  } vec_t;

  function automatic vec_t mk(input logic iv, input logic ordy, input logic fl,
                              input logic [31:0] pcv, input logic ov, input logic ir,
                              input logic [31:0] opc, input logic [15:0] st);
    vec_t v;
    v.iv = iv; v.ordy = ordy; v.fl = fl; v.pcv = pcv;
    v.ov = ov; v.ir = ir; v.opc = opc; v.st = st;
    return v;
  endfunction

  vec_t vecs[22];

  initial begin
    int n0;
    // Expected fields describe the state seen during the cycle, before its edge.
    vecs[0]  = mk(1'b1, 1'b1, 1'b0, 32'h10, 1'b0, 1'b1, 32'h0,  16'd0);
    vecs[1]  = mk(1'b1, 1'b1, 1'b0, 32'h11, 1'b1, 1'b1, 32'h10, 16'd0);
    vecs[2]  = mk(1'b1, 1'b1, 1'b0, 32'h40, 1'b1, 1'b1, 32'h11, 16'd0);
    vecs[3]  = mk(1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 1'b1, 32'h40, 16'd0);
    vecs[4]  = mk(1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 32'h0,  16'd0);
    vecs[5]  = mk(1'b1, 1'b0, 1'b0, 32'h20, 1'b0, 1'b1, 32'h0,  16'd0);
    vecs[6]  = mk(1'b1, 1'b0, 1'b0, 32'h21, 1'b1, 1'b1, 32'h20, 16'd0);
    vecs[7]  = mk(1'b1, 1'b0, 1'b0, 32'h22, 1'b1, 1'b0, 32'h20, 16'd1);
    vecs[8]  = mk(1'b1, 1'b0, 1'b0, 32'h22, 1'b1, 1'b0, 32'h20, 16'd2);
    vecs[9]  = mk(1'b1, 1'b1, 1'b0, 32'h22, 1'b1, 1'b0, 32'h20, 16'd3);
    vecs[10] = mk(1'b1, 1'b1, 1'b0, 32'h22, 1'b1, 1'b1, 32'h21, 16'd3);
    vecs[11] = mk(1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 1'b1, 32'h22, 16'd3);
    vecs[12] = mk(1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 32'h0,  16'd3);
    vecs[13] = mk(1'b1, 1'b0, 1'b0, 32'h31, 1'b0, 1'b1, 32'h0,  16'd3);
    vecs[14] = mk(1'b1, 1'b0, 1'b0, 32'h32, 1'b1, 1'b1, 32'h31, 16'd3);
    vecs[15] = mk(1'b1, 1'b0, 1'b1, 32'h30, 1'b1, 1'b0, 32'h31, 16'd4);
    vecs[16] = mk(1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 32'h0,  16'd4);
    vecs[17] = mk(1'b1, 1'b1, 1'b1, 32'h33, 1'b0, 1'b1, 32'h0,  16'd4);
    vecs[18] = mk(1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 32'h0,  16'd4);
    vecs[19] = mk(1'b1, 1'b1, 1'b0, 32'h34, 1'b0, 1'b1, 32'h0,  16'd4);
    vecs[20] = mk(1'b1, 1'b1, 1'b1, 32'h35, 1'b1, 1'b1, 32'h34, 16'd4);
    vecs[21] = mk(1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 32'h0,  16'd4);

    rst_n = 1'b0;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    flush0 = 1'b0; in_valid0 = 1'b0; out_ready0 = 1'b0;
    set_payload(32'h0);

    // Asynchronous reset state, before any clock edge.
    #3;
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_outputs", {o_instr, o_imm, o_pc, o_npc}, '0);
    chk("reset_stall", stall, 16'd0);
    chk("reset_out_valid0", out_valid0, 1'b0);

    @(posedge clk);
    #1 rst_n = 1'b1;
    #1 chk("reset_in_ready", in_ready, 1'b1);
    chk("reset_in_ready0", in_ready0, 1'b1);
    @(posedge clk);
    #1;

    // Table-driven sequence: streaming, drain, back-pressure, flush.
    for (int i = 0; i < 22; i++) begin
      in_valid  = vecs[i].iv;
      out_ready = vecs[i].ordy;
      flush     = vecs[i].fl;
      set_payload(vecs[i].pcv);
      #2;
      chk($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].ov);
      chk($sformatf("vec%0d_in_ready", i), in_ready, vecs[i].ir);
      chk($sformatf("vec%0d_oPc", i), o_pc, vecs[i].opc);
      chk($sformatf("vec%0d_stall", i), stall, vecs[i].st);
      @(posedge clk);
      #1;
    end

    // Reset mid-stream with head and skid full.
    cyc(1'b1, 1'b0, 1'b0, 32'h50);
    cyc(1'b1, 1'b0, 1'b0, 32'h51);
    chk("pre_reset_full", {out_valid, in_ready}, 2'b10);
    chk("pre_reset_stall_nonzero", stall != 16'd0, 1'b1);
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("midreset_out_valid", out_valid, 1'b0);
    chk("midreset_outputs", {o_instr, o_imm, o_pc, o_npc}, '0);
    chk("midreset_stall", stall, 16'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("midreset_in_ready", in_ready, 1'b1);
    chk("midreset_empty", out_valid, 1'b0);
    @(posedge clk);
    #1;

    // Back-to-back streaming sustains one transfer per cycle.
    n0 = n_consumed;
    for (int i = 0; i < 9; i++) cyc(1'b1, 1'b1, 1'b0, 32'h60 + 32'(i));
    chk("stream_throughput", n_consumed - n0, 8);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);

    // No-skid instance: combinational in_ready and 2-bit saturating counter.
    in_valid0  = 1'b1;
    out_ready0 = 1'b0;
    set_payload(32'h70);
    #1 chk("noskid_ready_empty", in_ready0, 1'b1);
    @(posedge clk);
    #1 in_valid0 = 1'b0;
    #1;
    chk("noskid_loaded", {out_valid0, o_pc0}, {1'b1, 32'h70});
    chk("noskid_ready_blocked", in_ready0, 1'b0);
    out_ready0 = 1'b1;
    #1 chk("noskid_ready_follows_hi", in_ready0, 1'b1);
    out_ready0 = 1'b0;
    #1 chk("noskid_ready_follows_lo", in_ready0, 1'b0);
    repeat (2) @(posedge clk);
    #1 chk("noskid_stall_2", stall0, 2'd2);
    repeat (3) @(posedge clk);
    #1 chk("noskid_stall_sat", stall0, 2'd3);
    out_ready0 = 1'b1;
    @(posedge clk);
    #1;
    chk("noskid_drain", {out_valid0, o_instr0, o_pc0}, '0);
    chk("noskid_stall_held", stall0, 2'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_id_pipe_buffer.md
Name: if_id_pipe_buffer

Overview:
Parametrised fetch/decode pipeline register with valid/ready flow control, flush and an optional 2-entry skid slot. It replaces the fixed-width always-load IF/ID register. It sits between the fetch stage (producer) and the decode stage (consumer) and carries instruction, immediate, PC and next-PC. It inserts zero-payload bubbles on flush or drain and counts back-pressure cycles for performance debug.

Parameters:
INSTR_W, 16, instruction field width
IMM_W, 16, immediate field width
PC_W, 32, PC and next-PC width
SKID_EN, 1, 1 = two-entry skid (in_ready registered); 0 = single entry (in_ready combinational)
CNT_W, 16, stall-counter width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  squash all held entries (branch/jump redirect)
in_valid  in  1  producer offers payload
in_ready  out  1  buffer can accept this cycle
instruction  in  INSTR_W  fetched instruction
imm  in  IMM_W  fetched immediate word
pc  in  PC_W  PC of instruction
nextPC  in  PC_W  predicted next PC
out_valid  out  1  oInstruction..oNextPC hold a live entry
out_ready  in  1  decode consumes this cycle
oInstruction  out  INSTR_W  head instruction
oimm  out  IMM_W  head immediate
oPc  out  PC_W  head PC
oNextPC  out  PC_W  head next PC
stall_cycles  out  CNT_W  saturating count of back-pressure cycles

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, all payload outputs 0, skid entry invalid and 0, stall_cycles=0. in_ready=1 once rst_n is high.
- Accept = in_valid & in_ready. Consume = out_valid & out_ready. Both are evaluated on the rising edge of clk.
- Latency: 1 cycle. A payload accepted in cycle N appears on the outputs with out_valid=1 in cycle N+1, provided the head is empty or being consumed.
- Head update priority, highest first: flush; skid valid & (consume | !out_valid) -> head=skid; accept & (consume | !out_valid) -> head=input; consume without refill -> out_valid=0 and payload zeroed (bubble); otherwise hold.
- SKID_EN=1:
  - in_ready = !skid_valid, registered with no combinational path from out_ready.
  - Accept while head is valid and not consumed -> input written to skid.
  - Skid drains into head on the next consume.
  - Accept and skid drain in the same cycle: skid moves to head and input is written to skid, so order is preserved.
- SKID_EN=0:
  - in_ready = !out_valid | out_ready (combinational). No skid storage is generated.
- Flush:
  - Next edge: out_valid=0, skid invalid, all payloads 0.
  - A simultaneous accept is dropped and a simultaneous consume still counts for decode.
  - in_ready=1 in the following cycle.
- Outputs are all-zero whenever out_valid=0; instruction 0 is the NOP encoding.
- Payload fields are never modified; widths pass through unchanged.
- stall_cycles increments by 1 on each edge where out_valid & !out_ready & !flush. It saturates at 2^CNT_W-1 and is cleared only by reset.
- Ordering: entries leave in acceptance order. No duplication, no loss except on flush.

Decomposition:
- Shared package: payload struct {instruction, imm, pc, nextPC} built from INSTR_W/IMM_W/PC_W; NOP_INSTR constant = 0.
- One natural sub-module: pipe_skid_slot, a single payload+valid register with load/clear. It is instantiated for the head and, under SKID_EN, for the skid.

Test Plan:
- Reset: assert rst_n=0 mid-stream with head and skid full -> outputs 0, out_valid=0, stall_cycles=0 immediately, without waiting for a clk edge; in_ready=1 after release.
- Streaming, out_ready=1: offer instruction=16'h1234, imm=16'h00AA, pc=32'h10, nextPC=32'h11 -> same values on the outputs the next cycle with out_valid=1; back-to-back issues sustain 1 per cycle.
- Back-pressure, SKID_EN=1: out_ready=0, send pc=0x20 then 0x21 -> head=0x20, skid=0x21, in_ready=0; third input held off; release gives 0x20 then 0x21 on consecutive cycles; stall_cycles equals the stalled cycle count.
- Flush with head and skid full and in_valid=1 (pc=0x30) -> next cycle out_valid=0, all outputs 0, in_ready=1; 0x30 is never emitted.
- Drain to bubble: single entry pc=0x40 consumed with no new input -> out_valid=0, oInstruction=0, oPc=0 the next cycle.
- SKID_EN=0, CNT_W=2: hold out_ready=0 for 5 cycles -> in_ready follows out_ready combinationally; stall_cycles saturates at 3.
